// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-tx states, timing defaults
// and the keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK
  } state_e;

  localparam int unsigned INHIBIT_DEF = 5000;
  localparam int unsigned TIMEOUT_DEF = 1000000;
  localparam int          TMR_W       = 20;

  localparam logic [7:0] CMD_SET_LED   = 8'hED;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request/outcome bundle between the requester
// and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_ack_err,
    input  tx_timeout
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_ack_err,
    output tx_timeout
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 pads with a registered
// falling-edge detect on each line.
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic clk_i,
  input  logic dat_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic clk_fe_o,
  output logic dat_fe_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;
  logic       dat_prev_q;

  // Reset to the idle-high level so no edge appears after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_ff_q   <= 2'b11;
      dat_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
      dat_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], clk_i};
      dat_ff_q   <= {dat_ff_q[0], dat_i};
      clk_prev_q <= clk_ff_q[1];
      dat_prev_q <= dat_ff_q[1];
    end
  end

  assign clk_s_o  = clk_ff_q[1];
  assign dat_s_o  = dat_ff_q[1];
  assign clk_fe_o = clk_prev_q & ~clk_ff_q[1];
  assign dat_fe_o = dat_prev_q & ~dat_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits,
// odd parity, stop, then device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_drive_low,
  output logic          ps2_dat_drive_low,
  output logic          rx_inhibit
);

  localparam logic [TMR_W-1:0] INH_LD =
    TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LD =
    TMR_W'(TIMEOUT_CYCLES - 1);

  logic clk_s;
  logic dat_s;
  logic clk_fe;
  logic unused_dat_fe;

  ps2_line_sync u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .clk_i    (ps2_clk_in),
    .dat_i    (ps2_dat_in),
    .clk_s_o  (clk_s),
    .dat_s_o  (dat_s),
    .clk_fe_o (clk_fe),
    .dat_fe_o (unused_dat_fe)
  );

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [2:0]       bit_q, bit_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             clk_dl_q, clk_dl_d;
  logic             dat_dl_q, dat_dl_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             to_q, to_d;

  logic       wait_dev;
  logic [2:0] bit_nxt;

  assign wait_dev = state_q inside {REQ, DATA, PARITY, STOP, ACK};
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    bit_d    = bit_q;
    tmr_d    = tmr_q;
    clk_dl_d = clk_dl_q;
    dat_dl_d = dat_dl_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx.tx_valid) begin
          data_d   = tx.tx_data;
          par_d    = odd_par(tx.tx_data);
          bit_d    = 3'd0;
          tmr_d    = INH_LD;
          clk_dl_d = 1'b1;
          dat_dl_d = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        tmr_d = tmr_q - 1'b1;
        // Start bit goes low on the last inhibit cycle
        if (tmr_q == TMR_W'(1)) dat_dl_d = 1'b1;
        if (tmr_q == '0) begin
          clk_dl_d = 1'b0;
          dat_dl_d = 1'b1;
          tmr_d    = TO_LD;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (clk_fe) begin
          dat_dl_d = ~data_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (clk_fe) begin
          if (bit_q == 3'd7) begin
            dat_dl_d = ~par_q;
            state_d  = PARITY;
          end else begin
            bit_d    = bit_nxt;
            dat_dl_d = ~data_q[bit_nxt];
          end
        end
      end
      PARITY: begin
        if (clk_fe) begin
          dat_dl_d = 1'b0;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (clk_fe) begin
          if (dat_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wait_dev) begin
      if (clk_fe) begin
        tmr_d = TO_LD;
      end else if (tmr_q == '0 && !done_d) begin
        to_d     = 1'b1;
        clk_dl_d = 1'b0;
        dat_dl_d = 1'b0;
        state_d  = IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      tmr_q    <= '0;
      clk_dl_q <= 1'b0;
      dat_dl_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      tmr_q    <= tmr_d;
      clk_dl_q <= clk_dl_d;
      dat_dl_q <= dat_dl_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign tx.tx_ready      = (state_q == IDLE);
  assign tx.tx_done       = done_q;
  assign tx.tx_ack_err    = err_q;
  assign tx.tx_timeout    = to_q;
  assign rx_inhibit       = (state_q != IDLE);
  assign ps2_clk_drive_low = clk_dl_q;
  assign ps2_dat_drive_low = dat_dl_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, clocking device
// model and an outcome scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 300;
  localparam int H   = 10;

  localparam logic [2:0] P_DONE = 3'b100;
  localparam logic [2:0] P_ERR  = 3'b010;
  localparam logic [2:0] P_TO   = 3'b001;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_RST    = 3;

  typedef struct {
    logic [2:0] pat;
    logic [7:0] b;
    logic       p;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_drive_low;
  logic ps2_dat_drive_low;
  logic rx_inhibit;
  logic [7:0] wire_byte = '0;
  logic wire_par = 1'b0;
  logic [2:0] pulses;
  int vectors = 0;
  int errs = 0;
  int inh_n = 0;
  int dat_at = 0;
  logic inh_prev = 1'b0;

  wire pad_clk = ~(ps2_clk_drive_low | dev_clk_low);
  wire pad_dat = ~(ps2_dat_drive_low | dev_dat_low);

  ps2_host_tx_if tx ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .tx                (tx),
    .ps2_clk_in        (pad_clk),
    .ps2_dat_in        (pad_dat),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low),
    .rx_inhibit        (rx_inhibit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every outcome pulse pops one expectation
  always @(negedge clk) begin
    pulses = {tx.tx_done, tx.tx_ack_err, tx.tx_timeout};
    if (pulses != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, pulses}, 0);
      end else begin
        e = q.pop_front();
        chk("outcome", {29'd0, pulses}, {29'd0, e.pat});
        chk("idle_outputs",
            {tx.tx_ready, rx_inhibit,
             ps2_clk_drive_low, ps2_dat_drive_low}, 4'b1000);
        if (e.pat != P_TO)
          chk("wire_byte", {wire_byte, wire_par}, {e.b, e.p});
      end
    end
  end

  // Inhibit length and start-bit placement, independent of the device
  always @(negedge clk) begin
    if (ps2_clk_drive_low === 1'b1) begin
      inh_n++;
      if (ps2_dat_drive_low === 1'b1 && dat_at == 0) dat_at = inh_n;
    end else if (inh_prev) begin
      chk("inhibit_len", inh_n, INH);
      chk("start_bit_cycle", dat_at, INH);
      inh_n  = 0;
      dat_at = 0;
    end
    inh_prev = (ps2_clk_drive_low === 1'b1);
  end

  task automatic dev_run(input int mode);
    int n;
    logic [11:1] s;
    s = '1;
    n = 0;
    while (ps2_clk_drive_low !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("inhibit_seen", ps2_clk_drive_low, 1);
    n = 0;
    while (ps2_clk_drive_low === 1'b1 && n < INH + 20) begin
      @(negedge clk);
      n++;
    end
    chk("clk_released", ps2_clk_drive_low, 0);
    if (mode == M_SILENT) begin
      n = 0;
      while (tx.tx_timeout !== 1'b1 && n < TO + 50) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", n, TO);
      return;
    end
    cyc(4);
    chk("start_held", pad_dat, 0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode == M_ACK) begin
        dev_dat_low = 1'b1;
        cyc(2);
      end
      dev_clk_low = 1'b1;
      cyc(H);
      s[k] = pad_dat;
      if (k == 9) begin
        wire_byte = s[8:1];
        wire_par  = s[9];
      end
      if (k == 10) chk("stop_bit", s[10], 1);
      if (mode == M_RST && k == 5) begin
        chk("pre_reset_drive", ps2_dat_drive_low, 1);
        #2 resetn = 1'b0;
        #1 chk("reset_release",
               {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
        dev_clk_low = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (k < 11) cyc(H);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx.tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", tx.tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    tx.tx_data  = b;
    tx.tx_valid = 1'b1;
    @(negedge clk);
    tx.tx_valid = 1'b0;
  endtask

  initial begin
    int n;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    cyc(3);
    @(negedge clk);
    chk("reset_state",
        {tx.tx_ready, rx_inhibit, ps2_clk_drive_low,
         ps2_dat_drive_low, tx.tx_done, tx.tx_ack_err,
         tx.tx_timeout}, 7'b1000000);
    resetn = 1'b1;

    q.push_back('{P_DONE, 8'hED, 1'b1});
    send(CMD_SET_LED);
    dev_run(M_ACK);
    wait_idle();

    q.push_back('{P_ERR, 8'hFF, 1'b1});
    send(CMD_RESET);
    dev_run(M_NOACK);
    wait_idle();

    q.push_back('{P_TO, 8'hF3, 1'b0});
    send(CMD_TYPEMATIC);
    dev_run(M_SILENT);
    wait_idle();

    send(8'h0F);
    dev_run(M_RST);
    repeat (3) begin
      @(negedge clk);
      chk("no_pulse_in_reset",
          {tx.tx_done, tx.tx_ack_err, tx.tx_timeout}, 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {tx.tx_ready, rx_inhibit}, 2'b10);

    wait_idle();
    q.push_back('{P_DONE, 8'h55, 1'b1});
    q.push_back('{P_DONE, 8'hAA, 1'b1});
    tx.tx_data  = 8'h55;
    tx.tx_valid = 1'b1;
    @(negedge clk);
    tx.tx_data = 8'hAA;
    dev_run(M_ACK);
    n = 0;
    while (tx.tx_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", tx.tx_done, 1);
    chk("b2b_done_ready", tx.tx_ready, 1);
    @(negedge clk);
    chk("b2b_accept", {ps2_clk_drive_low, tx.tx_ready}, 2'b10);
    tx.tx_valid = 1'b0;
    dev_run(M_ACK);
    wait_idle();

    q.push_back('{P_DONE, 8'h00, 1'b1});
    send(8'h00);
    dev_run(M_ACK);
    wait_idle();

    q.push_back('{P_DONE, 8'h01, 1'b0});
    send(8'h01);
    dev_run(M_ACK);
    wait_idle();

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
